// File: rtl/step_clock_generator.sv
// ----------------------------------------------------------------------------
// step_clock_generator
//
// Produces the processor clock for the ARMAria core from the board oscillator.
// In single-step mode each debounced press of the step button gives exactly one
// high pulse of PULSE_CYCLES; in free-run mode a press starts a free-running
// clock whose half period is (speed_sel+1)*BASE_HALF oscillator cycles.
//
// Ports
//   clk_fpga    in   board oscillator, all state changes on its rising edge
//   reset_fpga  in   synchronous active-high reset
//   step_button in   raw push-button, active-low, asynchronous
//   run_mode    in   board switch, asynchronous; 1 = free-run, 0 = single-step
//   speed_sel   in   [3:0] run-mode half-period multiplier minus one
//   clock       out  registered processor clock
//   clock_rise  out  one-cycle strobe coincident with clock going 0->1
//   running     out  high while free-running (RUN_LOW / RUN_HIGH)
//   cycle_count out  [COUNT_WIDTH-1:0] clock rising edges since reset (wraps)
// ----------------------------------------------------------------------------
module step_clock_generator #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned PULSE_CYCLES    = 25000,
    parameter int unsigned BASE_HALF       = 2500000,
    parameter int unsigned COUNT_WIDTH     = 32
) (
    input  logic                   clk_fpga,
    input  logic                   reset_fpga,
    input  logic                   step_button,
    input  logic                   run_mode,
    input  logic [3:0]             speed_sel,
    output logic                   clock,
    output logic                   clock_rise,
    output logic                   running,
    output logic [COUNT_WIDTH-1:0] cycle_count
);

    // Phase counter must cover the step pulse and the slowest run half period.
    localparam int unsigned RUN_MAX   = 16 * BASE_HALF;
    localparam int unsigned PHASE_MAX = (PULSE_CYCLES > RUN_MAX) ? PULSE_CYCLES : RUN_MAX;
    localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int unsigned DEB_W     = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PHASE_W-1:0] PULSE_LAST = PHASE_W'(PULSE_CYCLES - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStepHigh,
        StRunLow,
        StRunHigh
    } state_t;

    state_t             state;
    logic               btn_meta;
    logic               btn_sync;
    logic               run_meta;
    logic               run_sync;
    logic [DEB_W-1:0]   deb_cnt;
    logic               deb_level;
    logic               press_event;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_last;

    logic               btn_pressed;
    logic [31:0]        half_len;
    logic [PHASE_W-1:0] half_last;

    // Button is active-low on the board; work with pressed = 1 internally.
    assign btn_pressed = ~btn_sync;

    // Terminal phase count for a run half period at the current speed setting.
    assign half_len  = (32'(speed_sel) + 32'd1) * BASE_HALF;
    assign half_last = PHASE_W'(half_len - 32'd1);

    always_ff @(posedge clk_fpga) begin
        if (reset_fpga) begin
            state       <= StIdle;
            btn_meta    <= 1'b1;
            btn_sync    <= 1'b1;
            run_meta    <= 1'b0;
            run_sync    <= 1'b0;
            deb_cnt     <= '0;
            deb_level   <= 1'b0;
            press_event <= 1'b0;
            phase       <= '0;
            phase_last  <= '0;
            clock       <= 1'b0;
            clock_rise  <= 1'b0;
            running     <= 1'b0;
            cycle_count <= '0;
        end else begin
            btn_meta <= step_button;
            btn_sync <= btn_meta;
            run_meta <= run_mode;
            run_sync <= run_meta;

            // Debounce: accept a new level only after DEBOUNCE_CYCLES straight
            // cycles of disagreement; any agreement restarts the count.
            press_event <= 1'b0;
            if (btn_pressed != deb_level) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_level   <= btn_pressed;
                    deb_cnt     <= '0;
                    press_event <= btn_pressed;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end

            clock_rise <= 1'b0;

            unique case (state)
                StIdle: begin
                    clock   <= 1'b0;
                    running <= 1'b0;
                    phase   <= '0;
                    if (press_event) begin
                        if (run_sync) begin
                            state      <= StRunLow;
                            running    <= 1'b1;
                            phase_last <= half_last;
                        end else begin
                            state       <= StStepHigh;
                            clock       <= 1'b1;
                            clock_rise  <= 1'b1;
                            cycle_count <= cycle_count + 1'b1;
                            phase_last  <= PULSE_LAST;
                        end
                    end
                end

                StStepHigh: begin
                    if (phase == phase_last) begin
                        state <= StIdle;
                        clock <= 1'b0;
                        phase <= '0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                StRunLow: begin
                    if (!run_sync) begin
                        state   <= StIdle;
                        running <= 1'b0;
                        phase   <= '0;
                    end else if (phase == phase_last) begin
                        state       <= StRunHigh;
                        clock       <= 1'b1;
                        clock_rise  <= 1'b1;
                        cycle_count <= cycle_count + 1'b1;
                        phase       <= '0;
                        phase_last  <= half_last;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                StRunHigh: begin
                    // High phases always run to completion so the core never
                    // sees a runt clock pulse.
                    if (phase == phase_last) begin
                        clock <= 1'b0;
                        phase <= '0;
                        if (run_sync) begin
                            state      <= StRunLow;
                            phase_last <= half_last;
                        end else begin
                            state   <= StIdle;
                            running <= 1'b0;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                default: begin
                    state   <= StIdle;
                    clock   <= 1'b0;
                    running <= 1'b0;
                    phase   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/step_clock_generator.md
STEP_CLOCK_GENERATOR -- requirements
Module: step_clock_generator

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable clk_fpga cycles needed to accept a button level change.
REQ-002 SHALL have parameter PULSE_CYCLES, default 25000: clk_fpga cycles clock stays high per step pulse.
REQ-003 SHALL have parameter BASE_HALF, default 2500000: run-mode half-period unit, in clk_fpga cycles.
REQ-004 SHALL have parameter COUNT_WIDTH, default 32: width of cycle_count.
REQ-005 SHALL run on one clock, clk_fpga, with a synchronous, active-high reset, reset_fpga.
REQ-006 SHALL have port clk_fpga, input, 1 bit: board oscillator; all state changes on its rising edge.
REQ-007 SHALL have port reset_fpga, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port step_button, input, 1 bit: raw board push-button, active-low (0 = pressed), asynchronous to clk_fpga.
REQ-009 SHALL have port run_mode, input, 1 bit: board switch, asynchronous; 1 = free-run, 0 = single-step.
REQ-010 SHALL have port speed_sel, input, 4 bits: run-mode half period = (speed_sel+1)*BASE_HALF cycles.
REQ-011 SHALL have port clock, output, 1 bit: processor clock for the ARMAria core, registered.
REQ-012 SHALL have port clock_rise, output, 1 bit: one-cycle strobe, high in the same cycle that clock goes 0->1.
REQ-013 SHALL have port running, output, 1 bit: 1 while in RUN_LOW or RUN_HIGH.
REQ-014 SHALL have port cycle_count, output, COUNT_WIDTH bits: number of clock rising edges since reset.

Function
REQ-015 SHALL pass step_button and run_mode each through a 2-FF synchronizer before use.
REQ-016 SHALL invert the synchronized button so that pressed = 1.
REQ-017 SHALL debounce: the debounced level takes the synchronized value only after it differs from the current debounced level for DEBOUNCE_CYCLES consecutive cycles; any agreement clears the debounce counter.
REQ-018 SHALL generate press_event for one cycle when the debounced level goes 0->1; release generates no event.
REQ-019 SHALL implement FSM states IDLE, STEP_HIGH, RUN_LOW, RUN_HIGH with one phase counter shared by all timed states.
REQ-020 IDLE: clock = 0; on press_event with synchronized run_mode = 0 -> STEP_HIGH; with synchronized run_mode = 1 -> RUN_LOW (phase counter cleared).
REQ-021 STEP_HIGH: clock = 1 for exactly PULSE_CYCLES cycles, then -> IDLE with clock = 0.
REQ-022 SHALL ignore press_event in every state except IDLE, so one press produces at most one pulse.
REQ-023 RUN_LOW: clock = 0 for (speed_sel+1)*BASE_HALF cycles, then -> RUN_HIGH; if synchronized run_mode = 0, SHALL go -> IDLE immediately.
REQ-024 RUN_HIGH: clock = 1 for (speed_sel+1)*BASE_HALF cycles, then -> RUN_LOW if run_mode = 1, else -> IDLE; SHALL never truncate a high phase.
REQ-025 SHALL sample speed_sel at each phase start; a change mid-phase takes effect at the next phase.
REQ-026 SHALL enter RUN_LOW from IDLE only via a press when run_mode = 1; run_mode going 1 alone SHALL NOT start running.
REQ-027 Latency: press_event in cycle N -> clock = 1 and clock_rise = 1 in cycle N+1 (step mode); run entry -> first rise after one full low phase.
REQ-028 SHALL increment cycle_count by 1 on each clock_rise, wrapping modulo 2^COUNT_WIDTH from all-ones to 0.
REQ-029 SHALL size the phase counter to hold max(PULSE_CYCLES, 16*BASE_HALF) without overflow.

Reset
REQ-030 On reset_fpga = 1 at a clk_fpga edge, SHALL set state = IDLE, clock = 0, clock_rise = 0, running = 0, cycle_count = 0, phase and debounce counters = 0, debounced level = 0, button synchronizer = 1 (released), run_mode synchronizer = 0.
REQ-031 Reset asserted mid-pulse or mid-run SHALL force clock = 0 at the next edge, with no clock_rise; reset SHALL take priority over all other events.

Verification (DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, BASE_HALF=2, COUNT_WIDTH=4)
REQ-032 Step: run_mode=0, step_button low for 12 cycles -> exactly one clock pulse 3 cycles wide with one clock_rise, cycle_count = 1; holding 50 cycles -> still one pulse.
REQ-033 Bounce: step_button low for 3 cycles, high for 1, low for 3, then released -> no pulse, cycle_count = 0.
REQ-034 Run: run_mode=1, speed_sel=0, one press -> clock period of 4 cycles (2 low, 2 high), running = 1; after 5 rises cycle_count = 5; speed_sel=1 -> period of 8 cycles from the next phase.
REQ-035 Mode change: run_mode goes 0 during RUN_HIGH -> high phase completes its full 2 cycles, then clock = 0, running = 0, state IDLE; a later press gives a single 3-cycle pulse.
REQ-036 Wrap and reset: 16 rises -> cycle_count = 0; reset_fpga pulsed during STEP_HIGH -> clock = 0 next cycle, cycle_count = 0, no further pulse without a new press.
